// File: rtl/video_pkg.sv
// Shared video definitions: capture FSM encoding and default frame geometry,
// used by both the camera capture path and the VGA display timing.
package video_pkg;

  localparam int H_ACTIVE_DEF   = 1280;
  localparam int V_ACTIVE_DEF   = 720;
  localparam int FRAME_SKIP_DEF = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    WAIT_VS = 2'd2,
    CAPTURE = 2'd3
  } cap_state_t;

  function automatic int line_bytes(input int h_active);
    return 2 * h_active;
  endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Input register for a sensor sync line plus rise/fall pulses derived from the
// registered level and its previous-cycle value.
module cam_edge_det (
  input  logic cam_clk,
  input  logic cam_rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic level_d;

  always_ff @(posedge cam_clk or posedge cam_rst) begin
    if (cam_rst) begin
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level   <= din;
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/cmos_capture.sv
// Captures RGB565 bytes from a CMOS sensor, packs two pixels per 32-bit DDR
// write and reports per-frame start/done pulses with a geometry error status.
//
// state   | meaning
// IDLE    | DDR not ready, nothing captured
// SKIP    | counting sensor frames while the sensor settles
// WAIT_VS | settle done, waiting for the next frame boundary
// CAPTURE | packing bytes and writing words, frame after frame
module cmos_capture
  import video_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FRAME_SKIP = FRAME_SKIP_DEF
) (
  input  logic        cam_clk,
  input  logic        cam_rst,
  input  logic        ddr_init_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        ddr_wren,
  output logic [31:0] ddr_wdata,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err
);

  localparam logic [11:0] LINE_BYTES  = 12'(line_bytes(H_ACTIVE));
  localparam logic [9:0]  FRAME_LINES = 10'(V_ACTIVE);
  localparam logic [7:0]  SKIP_LOAD   = 8'((FRAME_SKIP > 0) ? FRAME_SKIP - 1 : 0);

  cap_state_t  state, state_nxt;
  logic        vs_level, vs_rise, vs_fall;
  logic        hr_level, hr_rise, hr_fall;
  logic [7:0]  data_q;
  logic [23:0] word_acc;
  logic [11:0] byte_cnt;
  logic [9:0]  line_cnt;
  logic [7:0]  skip_cnt;
  logic        err_flag;
  logic        take_byte, start_p, done_p, skip_load, skip_dec;
  logic        unused_edges;

  cam_edge_det u_vsync (
    .cam_clk (cam_clk),
    .cam_rst (cam_rst),
    .din     (cam_vsync),
    .level   (vs_level),
    .rise    (vs_rise),
    .fall    (vs_fall)
  );

  cam_edge_det u_href (
    .cam_clk (cam_clk),
    .cam_rst (cam_rst),
    .din     (cam_href),
    .level   (hr_level),
    .rise    (hr_rise),
    .fall    (hr_fall)
  );

  assign unused_edges = vs_level ^ vs_fall ^ hr_rise;

  always_ff @(posedge cam_clk or posedge cam_rst) begin
    if (cam_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_byte = 1'b0;
    start_p   = 1'b0;
    done_p    = 1'b0;
    skip_load = 1'b0;
    skip_dec  = 1'b0;
    if (!ddr_init_done) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = SKIP;
          skip_load = 1'b1;
        end
        SKIP: begin
          if (vs_rise) begin
            if (skip_cnt == 8'd0) state_nxt = WAIT_VS;
            else                  skip_dec  = 1'b1;
          end
        end
        WAIT_VS: begin
          if (vs_rise) begin
            state_nxt = CAPTURE;
            start_p   = 1'b1;
          end
        end
        CAPTURE: begin
          // a byte landing on the frame boundary belongs to no frame
          if (vs_rise) begin
            start_p = 1'b1;
            done_p  = (line_cnt != 10'd0);
          end else if (hr_level) begin
            take_byte = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge cam_clk or posedge cam_rst) begin
    if (cam_rst) begin
      data_q      <= 8'd0;
      word_acc    <= 24'd0;
      byte_cnt    <= 12'd0;
      line_cnt    <= 10'd0;
      skip_cnt    <= 8'd0;
      err_flag    <= 1'b0;
      ddr_wren    <= 1'b0;
      ddr_wdata   <= 32'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      data_q      <= cam_data;
      ddr_wren    <= 1'b0;
      frame_start <= start_p;
      frame_done  <= done_p;

      if (skip_load)     skip_cnt <= SKIP_LOAD;
      else if (skip_dec) skip_cnt <= skip_cnt - 8'd1;

      if (state != CAPTURE || !ddr_init_done) begin
        byte_cnt <= 12'd0;
        line_cnt <= 10'd0;
        err_flag <= 1'b0;
      end else if (vs_rise) begin
        byte_cnt <= 12'd0;
        line_cnt <= 10'd0;
        err_flag <= 1'b0;
        if (done_p) frame_err <= err_flag | (line_cnt != FRAME_LINES);
      end else if (hr_fall) begin
        // any trailing partial word is simply abandoned here
        byte_cnt <= 12'd0;
        line_cnt <= line_cnt + 10'd1;
        if (byte_cnt != LINE_BYTES) err_flag <= 1'b1;
      end else if (take_byte) begin
        byte_cnt <= byte_cnt + 12'd1;
        word_acc <= {word_acc[15:0], data_q};
        if (byte_cnt[1:0] == 2'd3) begin
          ddr_wdata <= {word_acc, data_q};
          ddr_wren  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_capture.sv
// Randomized bench for cmos_capture: a frame/line level model predicts written
// words (value and cycle), frame_done/frame_err events and frame_start count.
module tb_cmos_capture;
  import video_pkg::*;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int FS = 2;

  logic        cam_clk = 1'b0;
  logic        cam_rst = 1'b1;
  logic        ddr_init_done = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic        ddr_wren, frame_start, frame_done, frame_err;
  logic [31:0] ddr_wdata;

  cmos_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAME_SKIP(FS)) dut (
    .cam_clk       (cam_clk),
    .cam_rst       (cam_rst),
    .ddr_init_done (ddr_init_done),
    .cam_vsync     (cam_vsync),
    .cam_href      (cam_href),
    .cam_data      (cam_data),
    .ddr_wren      (ddr_wren),
    .ddr_wdata     (ddr_wdata),
    .frame_start   (frame_start),
    .frame_done    (frame_done),
    .frame_err     (frame_err)
  );

  always #5 cam_clk = ~cam_clk;

  int cyc = 0;
  always @(posedge cam_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // observed DUT activity
  logic [31:0] act_word[$];
  int          act_wcyc[$];
  bit          act_err[$];
  int          act_starts = 0;

  always @(negedge cam_clk) begin
    if (!cam_rst) begin
      if (ddr_wren) begin
        act_word.push_back(ddr_wdata);
        act_wcyc.push_back(cyc);
      end
      if (frame_start) act_starts++;
      if (frame_done) act_err.push_back(frame_err);
    end
  end

  // reference model: frame-level rules
  bit          m_init = 0, m_cap = 0, m_bad = 0;
  int          m_edges = 0, m_lines = 0;
  logic [31:0] exp_word[$];
  int          exp_wcyc[$];
  bit          exp_err[$];
  int          exp_starts = 0;
  logic [7:0]  ln_b[$];
  int          ln_c[$];
  logic [7:0]  dir_q[$];

  task automatic m_vsync_edge();
    if (!m_init) return;
    m_edges++;
    if (m_edges == FS + 1) begin
      m_cap = 1; exp_starts++; m_lines = 0; m_bad = 0;
    end else if (m_cap) begin
      exp_starts++;
      if (m_lines > 0) exp_err.push_back(m_bad || (m_lines != V));
      m_lines = 0; m_bad = 0;
    end
  endtask

  task automatic m_push_words(input int nwords);
    for (int w = 0; w < nwords; w++) begin
      exp_word.push_back({ln_b[4*w], ln_b[4*w+1], ln_b[4*w+2], ln_b[4*w+3]});
      exp_wcyc.push_back(ln_c[4*w+3] + 2);
    end
  endtask

  task automatic m_line();
    if (!m_cap) return;
    m_push_words(ln_b.size() / 4);
    m_lines++;
    if (ln_b.size() != 2 * H) m_bad = 1;
  endtask

  // stimulus
  task automatic drive_byte();
    logic [7:0] b;
    if (dir_q.size() > 0) b = dir_q.pop_front();
    else                  b = 8'($urandom);
    @(negedge cam_clk);
    cam_href = 1'b1;
    cam_data = b;
    ln_b.push_back(b);
    ln_c.push_back(cyc);
  endtask

  task automatic send_line(input int n);
    ln_b.delete(); ln_c.delete();
    repeat (n) drive_byte();
    @(negedge cam_clk);
    cam_href = 1'b0;
    cam_data = 8'($urandom);
    m_line();
    repeat (3) @(negedge cam_clk);
  endtask

  task automatic vsync_pulse();
    @(negedge cam_clk);
    cam_vsync = 1'b1;
    m_vsync_edge();
    repeat (3) @(negedge cam_clk);
    cam_vsync = 1'b0;
    repeat (3) @(negedge cam_clk);
  endtask

  task automatic rand_lines();
    int nl, n;
    nl = $urandom_range(0, 3);
    for (int i = 0; i < nl; i++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 11) : 2 * H;
      send_line(n);
    end
  endtask

  // drop DDR ready with href still high; the last driven byte is never used
  task automatic send_line_drop(input int keep);
    ln_b.delete(); ln_c.delete();
    repeat (keep) drive_byte();
    @(negedge cam_clk);
    ddr_init_done = 1'b0;
    cam_data = 8'($urandom);
    if (m_cap) m_push_words((keep - 1) / 4);
    m_init = 0; m_cap = 0; m_edges = 0;
    drive_byte();
    @(negedge cam_clk);
    cam_href = 1'b0;
    repeat (3) @(negedge cam_clk);
  endtask

  initial begin
    int nw, ne;
    repeat (3) @(negedge cam_clk);
    check_val("rst_wren", ddr_wren, 0);
    check_val("rst_wdata", ddr_wdata, 0);
    check_val("rst_start", frame_start, 0);
    check_val("rst_done", frame_done, 0);
    check_val("rst_err", frame_err, 0);
    check_val("rst_state", 32'(dut.state), 32'(IDLE));
    cam_rst = 1'b0;
    repeat (3) @(negedge cam_clk);

    vsync_pulse();                      // ignored: DDR not ready
    ddr_init_done = 1'b1; m_init = 1;
    repeat (4) @(negedge cam_clk);

    vsync_pulse(); rand_lines();        // skipped frame 1
    vsync_pulse(); rand_lines();        // skipped frame 2
    vsync_pulse();                      // capture starts
    dir_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    send_line(2 * H);
    send_line(2 * H);
    vsync_pulse();
    check_val("wdata_hold", ddr_wdata, exp_word[exp_word.size()-1]);

    send_line(6); send_line(2 * H); vsync_pulse();
    send_line(2 * H); send_line(2 * H); send_line(2 * H); vsync_pulse();
    send_line(2 * H); send_line(2 * H); vsync_pulse();
    vsync_pulse();                      // empty frame: start only

    for (int f = 0; f < 8; f++) begin
      rand_lines();
      vsync_pulse();
    end

    send_line(2 * H);
    send_line_drop(6);
    check_val("state_after_drop", 32'(dut.state), 32'(IDLE));
    vsync_pulse();
    ddr_init_done = 1'b1; m_init = 1;
    repeat (4) @(negedge cam_clk);
    vsync_pulse(); rand_lines();
    vsync_pulse(); rand_lines();
    vsync_pulse(); rand_lines();
    vsync_pulse();
    send_line(5); send_line(2 * H);
    vsync_pulse();
    send_line(2 * H);
    drive_byte(); drive_byte();
    @(negedge cam_clk);
    check_val("err_held", frame_err, exp_err[exp_err.size()-1]);
    #2 cam_rst = 1'b1;
    m_cap = 0; m_edges = 0;
    #1;
    check_val("midrst_wren", ddr_wren, 0);
    check_val("midrst_wdata", ddr_wdata, 0);
    check_val("midrst_start", frame_start, 0);
    check_val("midrst_done", frame_done, 0);
    check_val("midrst_err", frame_err, 0);
    check_val("midrst_state", 32'(dut.state), 32'(IDLE));
    cam_href = 1'b0;
    repeat (2) @(negedge cam_clk);
    cam_rst = 1'b0;
    repeat (5) @(negedge cam_clk);

    check_val("first_word", (act_word.size() > 0) ? act_word[0] : 32'd0, 32'h12345678);
    check_val("wren_count", 32'(act_word.size()), 32'(exp_word.size()));
    nw = (act_word.size() < exp_word.size()) ? act_word.size() : exp_word.size();
    for (int i = 0; i < nw; i++) begin
      check_val($sformatf("word[%0d]", i), act_word[i], exp_word[i]);
      check_val($sformatf("word_cyc[%0d]", i), 32'(act_wcyc[i]), 32'(exp_wcyc[i]));
    end
    check_val("done_count", 32'(act_err.size()), 32'(exp_err.size()));
    ne = (act_err.size() < exp_err.size()) ? act_err.size() : exp_err.size();
    for (int i = 0; i < ne; i++)
      check_val($sformatf("frame_err[%0d]", i), 32'(act_err[i]), 32'(exp_err[i]));
    check_val("start_count", 32'(act_starts), 32'(exp_starts));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmos_capture.md
CMOS_CAPTURE -- requirements
Module: cmos_capture

Interface
REQ-001 Parameter H_ACTIVE, default 1280, meaning: pixels per active line.
REQ-002 Parameter V_ACTIVE, default 720, meaning: active lines per frame.
REQ-003 Parameter FRAME_SKIP, default 10, meaning: complete frames discarded after ddr_init_done before capture starts (sensor settle).
REQ-004 cam_clk  in  1  pixel clock from the sensor; all logic runs on its rising edge.
REQ-005 cam_rst  in  1  reset, asynchronous, active-high.
REQ-006 ddr_init_done  in  1  DDR controller ready; level signal.
REQ-007 cam_vsync  in  1  frame sync, high = vertical blanking.
REQ-008 cam_href  in  1  line valid, high = active bytes on cam_data.
REQ-009 cam_data  in  8  sensor byte, RGB565, high byte first.
REQ-010 ddr_wren  out  1  one-cycle write strobe for ddr_wdata.
REQ-011 ddr_wdata  out  32  two packed pixels: first pixel [31:16], second pixel [15:0].
REQ-012 frame_start  out  1  one-cycle pulse at the start of each captured frame (writer resets its address).
REQ-013 frame_done  out  1  one-cycle pulse at the end of each captured frame.
REQ-014 frame_err  out  1  status of last completed frame: 1 = geometry mismatch; held until next frame_done.

Function
REQ-015 cam_vsync, cam_href, cam_data SHALL each pass through exactly one input register; all decisions use the registered copies.
REQ-016 vsync rising edge SHALL be detected from registered vsync against its previous-cycle value.
REQ-017 FSM states SHALL be IDLE, SKIP, WAIT_VS, CAPTURE.
REQ-018 IDLE -> SKIP when ddr_init_done = 1; SKIP counts vsync rising edges, -> WAIT_VS on the FRAME_SKIP-th edge.
REQ-019 WAIT_VS -> CAPTURE on the next vsync rising edge, same cycle frame_start pulses.
REQ-020 In CAPTURE each registered byte with href = 1 SHALL be shifted into a 32-bit assembly register, byte order b0 -> [31:24], b1 -> [23:16], b2 -> [15:8], b3 -> [7:0].
REQ-021 On the 4th byte of a word, ddr_wdata SHALL be updated and ddr_wren asserted for one cycle; latency from the 4th byte at pins to ddr_wren = 2 cam_clk.
REQ-022 ddr_wdata SHALL hold its value between strobes.
REQ-023 Byte counter (12 bits) SHALL clear on href falling edge; partial word (byte count not multiple of 4) at href fall SHALL be discarded, no strobe.
REQ-024 Line counter (10 bits) SHALL increment on each href falling edge in CAPTURE and clear on vsync rising edge.
REQ-025 Line whose byte count != 2*H_ACTIVE SHALL set an internal error flag for the frame.
REQ-026 On vsync rising edge in CAPTURE with line counter > 0: frame_done pulses, frame_err <= (error flag OR line counter != V_ACTIVE), error flag clears, frame_start pulses in the same cycle (back-to-back frames, FSM stays CAPTURE).
REQ-027 Vsync rising edge with line counter = 0 SHALL pulse frame_start only.
REQ-028 Byte coinciding with vsync rising edge SHALL be discarded (vsync wins).
REQ-029 ddr_init_done falling in any state SHALL force IDLE next cycle, discard partial word, no strobe, no frame_done.
REQ-030 Outside CAPTURE, ddr_wren, frame_start, frame_done SHALL stay 0.

Reset
REQ-031 cam_rst = 1 SHALL immediately force: state IDLE, ddr_wren 0, ddr_wdata 0, frame_start 0, frame_done 0, frame_err 0, all counters and input registers 0.
REQ-032 Reset release SHALL need no synchroniser inside this block; the top synchronises deassertion to cam_clk.

Structure
REQ-033 FSM state encoding and default H_ACTIVE/V_ACTIVE/FRAME_SKIP SHALL live in shared package video_pkg, also used by vga_disp timing.
REQ-034 One sub-module cam_edge_det (registered level + rise/fall pulses) SHALL be used for vsync and href; no further hierarchy.

Verification
REQ-035 Reset mid-frame: assert cam_rst during CAPTURE -> all outputs 0 same cycle, state IDLE.
REQ-036 FRAME_SKIP=2, init_done=1, 3 frames of 4x2 pixels -> frames 1-2 no strobes, frame 3 gives 4 strobes, one frame_start, one frame_done at 4th vsync edge.
REQ-037 Bytes 0x12,0x34,0x56,0x78 on one href -> ddr_wdata = 0x12345678, ddr_wren one cycle, 2 cam_clk after 0x78.
REQ-038 Line of 6 bytes (H_ACTIVE=4) -> one strobe, last 2 bytes dropped, frame_err = 1 at frame_done.
REQ-039 V_ACTIVE=2, frame with 3 correct lines -> frame_err = 1; next frame correct -> frame_err = 0.
REQ-040 Drop ddr_init_done after 2 bytes of a word -> no strobe, no frame_done, state IDLE; re-raise -> FRAME_SKIP frames skipped again.
